// File: rtl/shared_pkg.sv
// Shared types and default widths for the SPI/host RAM arbiter.
package shared_pkg;

  localparam int MEM_WIDTH = 8;
  localparam int ADDR_SIZE = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RDATA = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin grant (SPI vs host). On a tie the requester that
// did not win last time is chosen; last_grant only moves when advance_i is set.
module arb_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_spi_i,
  input  logic req_host_i,
  input  logic advance_i,
  output logic gnt_any_o,
  output logic gnt_host_o
);
  import shared_pkg::*;

  owner_e last_grant_q;
  owner_e last_grant_d;

  assign gnt_any_o = req_spi_i | req_host_i;

  always_comb begin
    gnt_host_o = req_host_i;
    if (req_spi_i && req_host_i) begin
      gnt_host_o = (last_grant_q == OWN_SPI);
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i && gnt_any_o) begin
      last_grant_d = gnt_host_o ? OWN_HOST : OWN_SPI;
    end
  end

  // Reset to HOST so SPI wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= OWN_HOST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between an SPI command stream and a host port.
// SPI data accesses wait in a one-entry buffer; the host holds its request until granted.
module spi_ram_arbiter #(
  parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH,
  parameter int ADDR_SIZE = shared_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MEM_WIDTH+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [MEM_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [MEM_WIDTH-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata,
  output logic                 spi_ovf,
  output logic [1:0]           dbg_state_o
);
  import shared_pkg::*;

  arb_state_e           state_q;
  logic                 pend_q;
  logic                 pend_we_q;
  logic [ADDR_SIZE-1:0] pend_addr_q;
  logic [MEM_WIDTH-1:0] pend_data_q;
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  owner_e               owner_q;
  logic                 cap_we_q;
  logic [ADDR_SIZE-1:0] cap_addr_q;
  logic [MEM_WIDTH-1:0] cap_data_q;
  logic [MEM_WIDTH-1:0] tx_data_q;
  logic                 tx_valid_q;
  logic [MEM_WIDTH-1:0] host_rdata_q;
  logic                 host_rvalid_q;
  logic                 spi_ovf_q;

  spi_cmd_e             rx_cmd;
  logic [MEM_WIDTH-1:0] rx_payload;
  logic                 rx_access;
  logic                 in_idle;
  logic                 gnt_any;
  logic                 gnt_host;
  logic                 grant_fire;
  logic                 spi_take;

  assign rx_cmd     = spi_cmd_e'(rx_data[MEM_WIDTH+1:MEM_WIDTH]);
  assign rx_payload = rx_data[MEM_WIDTH-1:0];
  assign rx_access  = rx_valid && (rx_cmd == WR_DATA || rx_cmd == RD_DATA);
  assign in_idle    = (state_q == ARB_IDLE);

  arb_rr2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_spi_i  (pend_q),
    .req_host_i (host_req),
    .advance_i  (in_idle),
    .gnt_any_o  (gnt_any),
    .gnt_host_o (gnt_host)
  );

  // Handshake: the host holds req/we/addr/wdata stable; the cycle in which
  // host_gnt is high is the transfer cycle, after which the host may move on.
  assign grant_fire = in_idle && gnt_any;
  assign spi_take   = grant_fire && !gnt_host;
  assign host_gnt   = grant_fire && gnt_host;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      pend_q        <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      owner_q       <= OWN_SPI;
      cap_we_q      <= 1'b0;
      cap_addr_q    <= '0;
      cap_data_q    <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      spi_ovf_q     <= 1'b0;
    end else begin
      tx_valid_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      spi_ovf_q     <= 1'b0;

      if (rx_valid && rx_cmd == WR_ADDR) wr_addr_q <= ADDR_SIZE'(rx_payload);
      if (rx_valid && rx_cmd == RD_ADDR) rd_addr_q <= ADDR_SIZE'(rx_payload);

      // A new SPI access loaded in the grant cycle is a refill, not an overflow.
      if (spi_take) pend_q <= 1'b0;
      if (rx_access) begin
        pend_q      <= 1'b1;
        pend_we_q   <= (rx_cmd == WR_DATA);
        pend_addr_q <= (rx_cmd == WR_DATA) ? wr_addr_q : rd_addr_q;
        pend_data_q <= rx_payload;
        if (pend_q && !spi_take) spi_ovf_q <= 1'b1;
      end

      case (state_q)
        ARB_IDLE: begin
          if (grant_fire) begin
            owner_q    <= gnt_host ? OWN_HOST : OWN_SPI;
            cap_we_q   <= gnt_host ? host_we : pend_we_q;
            cap_addr_q <= gnt_host ? host_addr : pend_addr_q;
            cap_data_q <= gnt_host ? host_wdata : pend_data_q;
            state_q    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          state_q <= cap_we_q ? ARB_IDLE : ARB_RDATA;
        end
        ARB_RDATA: begin
          if (owner_q == OWN_HOST) begin
            host_rdata_q  <= ram_rdata;
            host_rvalid_q <= 1'b1;
          end else begin
            tx_data_q  <= ram_rdata;
            tx_valid_q <= 1'b1;
          end
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ram_en      = (state_q == ARB_ISSUE);
  assign ram_we      = ram_en && cap_we_q;
  assign ram_addr    = cap_addr_q;
  assign ram_wdata   = cap_data_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign spi_ovf     = spi_ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed scenarios plus randomized SPI/host traffic
// checked against a shadow-memory model with cycle-accurate latency expectations.
module tb_spi_ram_arbiter;
  import shared_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       spi_ovf;
  logic [1:0] dbg_state;

  spi_ram_arbiter #(.MEM_WIDTH(8), .ADDR_SIZE(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .spi_ovf     (spi_ovf),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM environment: read data valid the cycle after a read enable
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model state and observation queues
  logic [7:0]  sh [256];
  logic [15:0] exp_q[$];
  int          exp_rx_q[$];
  logic [15:0] obs_wr_q[$];
  int          obs_wr_cyc_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  logic [7:0]  hrv_q[$];
  int          hrv_cyc_q[$];
  int          ovf_cnt = 0;
  int          ram_en_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(negedge clk) begin
    if (ram_en) ram_en_cnt++;
    if (ram_en && ram_we) begin
      obs_wr_q.push_back({ram_addr, ram_wdata});
      obs_wr_cyc_q.push_back(cyc);
    end
    if (tx_valid) begin
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
    end
    if (host_rvalid) begin
      hrv_q.push_back(host_rdata);
      hrv_cyc_q.push_back(cyc);
    end
    if (spi_ovf) ovf_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Driver tasks
  task automatic spi_send(input logic [1:0] cmd, input logic [7:0] pl, output int rxc);
    @(posedge clk); #1;
    rx_data = {cmd, pl};
    rx_valid = 1'b1;
    rxc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_gnt(output int gcyc);
    gcyc = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (host_gnt) begin
        gcyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (gcyc < 0) check_eq("host_gnt_timeout", 0, 1);
  endtask

  task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d, output int gcyc);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    wait_gnt(gcyc);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  // Scoreboard pops
  task automatic pop_wr(input string tag, input logic [7:0] ea, input logic [7:0] ed,
                        input int ref_cyc, input int lo, input int hi);
    logic [15:0] w;
    int c;
    if (obs_wr_q.size() == 0) begin
      check_eq({tag, "_missing"}, 0, 1);
    end else begin
      w = obs_wr_q.pop_front();
      c = obs_wr_cyc_q.pop_front();
      check_eq({tag, "_addr"}, w[15:8], ea);
      check_eq({tag, "_data"}, w[7:0], ed);
      if (lo == hi) check_eq({tag, "_lat"}, c - ref_cyc, lo);
      else          check_eq({tag, "_lat_in_range"}, (c - ref_cyc >= lo) && (c - ref_cyc <= hi), 1);
    end
  endtask

  task automatic pop_tx(input string tag, input logic [7:0] ed, input int ecyc);
    if (tx_q.size() == 0) begin
      check_eq({tag, "_missing"}, 0, 1);
    end else begin
      check_eq({tag, "_data"}, tx_q.pop_front(), ed);
      check_eq({tag, "_cyc"}, tx_cyc_q.pop_front(), ecyc);
    end
  endtask

  task automatic pop_hrv(input string tag, input logic [7:0] ed, input int ecyc);
    if (hrv_q.size() == 0) begin
      check_eq({tag, "_missing"}, 0, 1);
    end else begin
      check_eq({tag, "_data"}, hrv_q.pop_front(), ed);
      check_eq({tag, "_cyc"}, hrv_cyc_q.pop_front(), ecyc);
    end
  endtask

  task automatic clear_obs();
    obs_wr_q.delete(); obs_wr_cyc_q.delete();
    tx_q.delete(); tx_cyc_q.delete();
    hrv_q.delete(); hrv_cyc_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nw, g, ovf0, en0, c30, c40, c11, op;
    logic [7:0] a, d, d30;
    for (int i = 0; i < 256; i++) sh[i] = 8'(i) ^ 8'h5A;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state, ARB_IDLE);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_host_rvalid", host_rvalid, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_spi_ovf", spi_ovf, 0);
    check_eq("rst_host_gnt", host_gnt, 0);
    check_eq("rst_ram_bus", {ram_we, ram_addr, ram_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention right after reset: SPI write to wr_addr 0, host read at 0x20
    @(posedge clk); #1;
    rx_data = {2'b01, 8'h3C}; rx_valid = 1'b1; n = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20; host_wdata = 8'h00;
    wait_gnt(g);
    check_eq("cont_host_gnt_cyc", g, n + 3);
    @(posedge clk); #1;
    host_req = 1'b0;
    repeat (5) @(posedge clk);
    pop_wr("cont_spi_wr", 8'h00, 8'h3C, n, 2, 2);
    sh[8'h00] = 8'h3C;
    pop_hrv("cont_host_rd", sh[8'h20], g + 3);

    // SPI round trip
    clear_obs();
    spi_send(2'b00, 8'h12, n);
    spi_send(2'b01, 8'hA5, nw);
    spi_send(2'b10, 8'h12, n);
    spi_send(2'b11, 8'h00, n);
    repeat (6) @(posedge clk);
    pop_wr("rt_wr", 8'h12, 8'hA5, nw, 2, 2);
    sh[8'h12] = 8'hA5;
    pop_tx("rt_tx", 8'hA5, n + 4);
    repeat (3) @(posedge clk); #1;
    check_eq("rt_tx_hold", tx_data, 8'hA5);

    // Overflow while the host streams writes
    clear_obs();
    ovf0 = ovf_cnt;
    spi_send(2'b00, 8'h30, n);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h55;
    wait_gnt(g);
    rx_data = {2'b01, 8'h11}; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_data = {2'b01, 8'h22};
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    host_req = 1'b0;
    repeat (3) @(posedge clk);
    c30 = 0; c40 = 0; c11 = 0; d30 = '0;
    foreach (obs_wr_q[i]) begin
      if (obs_wr_q[i][15:8] == 8'h30) begin c30++; d30 = obs_wr_q[i][7:0]; end
      if (obs_wr_q[i] == 16'h4055) c40++;
      if (obs_wr_q[i][7:0] == 8'h11) c11++;
    end
    check_eq("ovf_pulses", ovf_cnt - ovf0, 1);
    check_eq("ovf_wr30_count", c30, 1);
    check_eq("ovf_wr30_data", d30, 8'h22);
    check_eq("ovf_no_0x11", c11, 0);
    check_eq("ovf_host_wr_seen", c40 > 1, 1);
    sh[8'h30] = 8'h22;
    sh[8'h40] = 8'h55;

    // Fairness soak: host reads held continuously, SPI write every 10 cycles
    clear_obs();
    ovf0 = ovf_cnt;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h50;
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom_range(128, 255));
      d = 8'($urandom);
      spi_send(2'b00, a, n);
      spi_send(2'b01, d, n);
      exp_q.push_back({a, d});
      exp_rx_q.push_back(n);
      repeat (6) @(posedge clk);
    end
    @(posedge clk); #1;
    host_req = 1'b0;
    repeat (6) @(posedge clk);
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      pop_wr("soak_wr", e[15:8], e[7:0], exp_rx_q.pop_front(), 2, 6);
      sh[e[15:8]] = e[7:0];
    end
    check_eq("soak_no_ovf", ovf_cnt - ovf0, 0);
    check_eq("soak_host_served", hrv_q.size() > 8, 1);

    // Randomized mixed traffic against the shadow memory
    clear_obs();
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 3);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      case (op)
        0: begin
          spi_send(2'b00, a, n);
          spi_send(2'b01, d, n);
          repeat (4) @(posedge clk);
          pop_wr("rnd_spi_wr", a, d, n, 2, 2);
          sh[a] = d;
        end
        1: begin
          spi_send(2'b10, a, n);
          spi_send(2'b11, d, n);
          repeat (6) @(posedge clk);
          pop_tx("rnd_spi_rd", sh[a], n + 4);
        end
        2: begin
          host_access(1'b1, a, d, g);
          repeat (2) @(posedge clk);
          pop_wr("rnd_host_wr", a, d, g, 1, 1);
          sh[a] = d;
        end
        default: begin
          host_access(1'b0, a, 8'h00, g);
          repeat (4) @(posedge clk);
          pop_hrv("rnd_host_rd", sh[a], g + 3);
        end
      endcase
    end

    // Reset during the read-data phase of a host read
    clear_obs();
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    wait_gnt(g);
    @(posedge clk); #1;
    host_req = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_in_rdata", dbg_state, ARB_RDATA);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_state", dbg_state, ARB_IDLE);
    check_eq("mid_host_rvalid", host_rvalid, 0);
    check_eq("mid_host_rdata", host_rdata, 0);
    check_eq("mid_tx", {tx_valid, tx_data}, 0);
    check_eq("mid_ram_en", ram_en, 0);
    check_eq("mid_gnt_ovf", {host_gnt, spi_ovf}, 0);
    en0 = ram_en_cnt;
    ovf0 = ovf_cnt;
    repeat (6) @(posedge clk);
    check_eq("mid_no_rvalid_after", hrv_q.size(), 0);
    check_eq("mid_no_ram_en_after", ram_en_cnt - en0, 0);
    check_eq("mid_no_ovf_after", ovf_cnt - ovf0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 8: RAM data width.
REQ-002 SHALL have parameter ADDR_SIZE, default 8: RAM address width.
REQ-003 SHALL have port clk  in  1: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n  in  1: synchronous, active-low reset.
REQ-005 SHALL have port rx_data  in  MEM_WIDTH+2: the SPI slave word, made up of cmd[MEM_WIDTH+1:MEM_WIDTH] and payload[MEM_WIDTH-1:0].
REQ-006 SHALL have port rx_valid  in  1: one-cycle strobe that qualifies rx_data.
REQ-007 SHALL have port tx_data  out  MEM_WIDTH: SPI read data.
REQ-008 SHALL have port tx_valid  out  1: one-cycle strobe that qualifies tx_data.
REQ-009 SHALL have ports host_req  in  1 / host_we  in  1 / host_addr  in  ADDR_SIZE / host_wdata  in  MEM_WIDTH: the second requester; it holds these stable until it receives a grant.
REQ-010 SHALL have port host_gnt  out  1: one-cycle pulse that marks host request acceptance.
REQ-011 SHALL have ports host_rdata  out  MEM_WIDTH / host_rvalid  out  1: host read return.
REQ-012 SHALL have ports ram_en  out  1 / ram_we  out  1 / ram_addr  out  ADDR_SIZE / ram_wdata  out  MEM_WIDTH / ram_rdata  in  MEM_WIDTH: single-port RAM; read data is valid one cycle after an ram_en read.
REQ-013 SHALL have port spi_ovf  out  1: one-cycle pulse that flags a dropped SPI access.

Function
REQ-014 SHALL decode cmd as follows:
- 00 = write-address: latch payload into wr_addr.
- 01 = write-data.
- 10 = read-address: latch payload into rd_addr.
- 11 = read-data: payload ignored.
REQ-015 SHALL process cmd 00/10 on the rx_valid edge itself, with no RAM access.
REQ-016 SHALL, on rx_valid with cmd 01/11, load a one-entry SPI pending buffer with {we, address (wr_addr or rd_addr current value), payload}.
REQ-017 SHALL, if rx_valid with cmd 01/11 arrives while the buffer is pending and not granted that cycle, overwrite the entry and pulse spi_ovf.
REQ-018 SHALL implement the FSM states ARB_IDLE, ARB_ISSUE and ARB_RDATA.
REQ-019 SHALL, in ARB_IDLE, grant among SPI-pending and host_req; when both are present it grants round-robin against last_grant; otherwise it grants the sole requester.
REQ-020 SHALL, on a grant in ARB_IDLE, capture the access (host_gnt=1 in that cycle for host; clear pending for SPI) and move to ARB_ISSUE.
REQ-021 SHALL, in ARB_ISSUE, drive ram_en=1 with the captured we/addr/wdata; a write returns to ARB_IDLE and a read moves to ARB_RDATA.
REQ-022 SHALL, in ARB_RDATA, register ram_rdata into tx_data or host_rdata per owner, pulse the matching valid in the next cycle, and move to ARB_IDLE.
REQ-023 SHALL hold ram_en=0 and host_gnt=0 outside the states above.
REQ-024 SHALL give these latencies:
- host read: host_gnt at cycle N gives host_rvalid at N+3.
- SPI read: rx_valid at cycle N with buffer free and no contention gives tx_valid at N+4.
REQ-025 SHALL have a peak throughput of one write per 2 cycles and one read per 3 cycles.
REQ-026 SHALL hold tx_data and host_rdata at their last value between strobes.

Reset
REQ-027 SHALL, while rst_n=0 at a rising edge, set the following:
- state = ARB_IDLE.
- pending cleared.
- wr_addr = rd_addr = 0.
- last_grant = HOST, so SPI wins the first tie.
- all outputs 0 in the following cycle.
REQ-028 SHALL, on reset mid-access, abandon the access: no valid strobe, no ram_en, no spi_ovf afterwards.

Structure
REQ-029 SHALL place arb_state_e, spi_cmd_e (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), owner_e (OWN_SPI, OWN_HOST), MEM_WIDTH and ADDR_SIZE in shared_pkg.
REQ-030 SHALL instantiate one sub-module, arb_rr2: a two-requester round-robin grant with last_grant state.

Verification
REQ-031 SHALL cover the SPI round trip:
- stimulus: cmd00 payload 0x12, then cmd01 payload 0xA5, then cmd10 payload 0x12, then cmd11.
- required: ram_we write of 0xA5 to address 0x12; tx_data=0xA5 with tx_valid 4 cycles after the cmd11 rx_valid.
REQ-032 SHALL cover contention: SPI pending and host_req read at 0x20 in the same IDLE cycle after reset -> SPI granted first; host_gnt exactly one ARB_IDLE later; host_rvalid 3 cycles after host_gnt.
REQ-033 SHALL cover overflow: two cmd01 words (0x11, then 0x22) while host holds back-to-back writes -> spi_ovf pulses once; RAM receives 0x22 only.
REQ-034 SHALL cover reset mid-access: rst_n=0 during ARB_RDATA of a host read -> no host_rvalid; state ARB_IDLE; outputs 0 next cycle.
REQ-035 SHALL cover a fairness soak: host_req held continuously plus SPI cmd01 every 10 cycles -> every SPI write lands within 6 cycles of rx_valid; no spi_ovf.
